u_type_exec_ctrl: RTL and testbench
===================================

Name: u_type_exec_ctrl

Overview:
- Sequences execution and register-file writeback of U-type instructions (LUI, AUIPC).
- Accepts an instruction word plus PC through a valid/ready handshake and splits it into the 20-bit upper immediate and rd.
- Forms the 32-bit result, then requests the shared register-file write port and holds the request until granted.
- Sits between fetch/issue and the register-file write arbiter.

Parameters:
- XLEN, 32, datapath and PC width; only 32 is supported.
- CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction_word/pc valid
- in_ready  output  1  block can accept a new instruction
- instruction_word  input  32  raw instruction
- pc  input  XLEN  address of instruction_word
- wb_req  output  1  register-file write request
- wb_gnt  input  1  write port granted this cycle
- wb_rd  output  5  destination register
- wb_data  output  XLEN  value to write
- done  output  1  one-cycle pulse: instruction retired
- illegal  output  1  one-cycle pulse: opcode not LUI/AUIPC
- retire_cnt  output  CNT_W  retired count (RETIRE_CNT_EN only)

Behaviour:
- Clock and reset: single clock domain. rst_n asserts asynchronously and deasserts synchronously at the system level.
- Reset values: state=IDLE, in_ready=1, wb_req=0, wb_rd=0, wb_data=0, done=0, illegal=0, retire_cnt=0.
- Reset mid-operation: any in-flight instruction is dropped and no write is issued.
- Opcode decode (instruction_word[6:0]):
  - 0110111 = LUI
  - 0010111 = AUIPC
  - all others = illegal
- Field extraction: imm = instruction_word[31:12]; rd = instruction_word[11:7].
- Result:
  - LUI: {imm, 12'h000}
  - AUIPC: pc + {imm, 12'h000}, modulo 2^32; carry discarded, wrap-around is legal.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch opcode, imm, rd and pc into internal registers, then go to EXEC.
  - in_ready drops to 0 the cycle after acceptance.
- EXEC (exactly one cycle, in_ready=0):
  - Opcode illegal: pulse illegal=1 next cycle, go to IDLE, no write.
  - rd==0: compute nothing architectural, pulse done=1 next cycle, go to IDLE, wb_req stays 0.
  - Otherwise: register wb_data/wb_rd, set wb_req=1, go to WB.
- WB:
  - wb_req, wb_rd and wb_data are held stable until wb_gnt=1 is sampled high.
  - In the cycle wb_gnt=1 is sampled: wb_req clears next cycle, done pulses next cycle, go to IDLE.
  - wb_gnt while wb_req=0 is ignored.
- Latency: accept at edge T; wb_req high after edge T+1; minimum acceptance-to-done is 3 edges when wb_gnt is already high.
- Throughput: next in_valid is accepted no earlier than the IDLE cycle after done/illegal. Back-to-back in_valid while busy is not accepted; the source must hold it.
- done and illegal are never asserted in the same cycle.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined:
  - retire_cnt increments by 1 on every done pulse, including rd==0 retirements; illegal does not count.
  - Wraps from 2^CNT_W-1 to 0.
  - Cleared by rst_n.
- Undefined: retire_cnt port is absent and no counter logic is built.

Test Plan:
- LUI: instruction 0x123452B7, pc=0x0 -> wb_req=1 with wb_rd=5, wb_data=0x12345000; wb_gnt same cycle -> done one cycle later, in_ready=1 after.
- AUIPC: 0x00001197, pc=0x00000100 -> wb_rd=3, wb_data=0x00001100. Wrap check: 0xFFFFF197, pc=0x00002000 -> wb_data=0x00001000.
- rd=0: 0x00001037 -> wb_req never asserts, done pulses once; retire_cnt 0->1 when RETIRE_CNT_EN is defined.
- Illegal opcode: 0x00000013 -> illegal pulses one cycle, no wb_req, retire_cnt unchanged, block returns to IDLE.
- Delayed grant: wb_gnt held low 3 cycles after wb_req -> wb_req/wb_rd/wb_data remain stable all 3 cycles; done only after wb_gnt=1. in_valid pulsed during the wait is not accepted (in_ready=0).
- Reset during WB: rst_n low while wb_req=1 -> wb_req=0 immediately (async), no done; after release a new LUI completes normally.

Source files
------------

// File: rtl/u_type_exec_ctrl.sv
// u_type_exec_ctrl
//   Executes U-type instructions (LUI, AUIPC) and sequences the result onto
//   the shared register-file write port.
//
//   An instruction/PC pair is taken through a valid/ready handshake. One
//   execute cycle follows, and then a write request is held until the
//   arbiter grants it. Illegal opcodes and rd==0 retire without any write.
//
// Parameters
//   XLEN   datapath / PC width (only 32 is supported)
//   CNT_W  width of the retired-instruction counter
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready instruction handshake
//   instruction_word  raw 32-bit instruction
//   pc                address of instruction_word
//   wb_req/wb_gnt     register-file write request / grant
//   wb_rd, wb_data    destination register and value, stable while wb_req
//   done              one-cycle pulse per retired instruction
//   illegal           one-cycle pulse when the opcode is neither LUI nor AUIPC
//   retire_cnt        retired-instruction count (only with RETIRE_CNT_EN)
//
// Build option
//   RETIRE_CNT_EN  when defined, adds the retire_cnt port and counter.
//                  The default build has neither.

module u_type_exec_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction_word,
  input  logic [XLEN-1:0]  pc,
  output logic             wb_req,
  input  logic             wb_gnt,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             done,
  output logic             illegal
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  // Elaboration-time parameter sanity.
  if (XLEN != 32) begin : g_bad_xlen
    $error("u_type_exec_ctrl: only XLEN=32 is supported");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("u_type_exec_ctrl: CNT_W must be at least 1");
  end

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  typedef enum logic [1:0] {
    OP_LUI,
    OP_AUIPC,
    OP_ILLEGAL
  } op_e;

  state_e state_q, state_d;

  // Instruction fields captured at acceptance.
  op_e             op_q;
  logic [19:0]     imm_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] pc_q;

  // Next values for the registered outputs.
  logic            in_ready_d;
  logic            wb_req_d;
  logic [4:0]      wb_rd_d;
  logic [XLEN-1:0] wb_data_d;
  logic            done_d;
  logic            illegal_d;
  logic            accept;

  op_e             op_dec;
  logic [XLEN-1:0] upper_imm;
  logic [XLEN-1:0] result;

  // Opcode decode on the incoming word; only the decoded class is stored.
  always_comb begin
    op_dec = OP_ILLEGAL;
    case (instruction_word[6:0])
      OPC_LUI:   op_dec = OP_LUI;
      OPC_AUIPC: op_dec = OP_AUIPC;
      default:   op_dec = OP_ILLEGAL;
    endcase
  end

  // U-type result; the AUIPC sum wraps modulo 2^XLEN (carry dropped).
  always_comb begin
    upper_imm = {imm_q, 12'h000};
    result    = upper_imm;
    if (op_q == OP_AUIPC) begin
      result = pc_q + upper_imm;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready;
    wb_req_d   = wb_req;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          in_ready_d = 1'b0;
          state_d    = S_EXEC;
        end
      end

      S_EXEC: begin
        // An illegal opcode wins over rd==0: no retirement is reported.
        if (op_q == OP_ILLEGAL) begin
          illegal_d  = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else if (rd_q == 5'd0) begin
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wb_req_d  = 1'b1;
          wb_rd_d   = rd_q;
          wb_data_d = result;
          state_d   = S_WB;
        end
      end

      S_WB: begin
        // Request, rd and data stay put until the grant is sampled.
        if (wb_gnt) begin
          wb_req_d   = 1'b0;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      default: begin
        wb_req_d   = 1'b0;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      in_ready <= 1'b1;
      wb_req   <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= in_ready_d;
      wb_req   <= wb_req_d;
      wb_rd    <= wb_rd_d;
      wb_data  <= wb_data_d;
      done     <= done_d;
      illegal  <= illegal_d;
    end
  end

  // Instruction capture on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ILLEGAL;
      imm_q <= '0;
      rd_q  <= '0;
      pc_q  <= '0;
    end else if (accept) begin
      op_q  <= op_dec;
      imm_q <= instruction_word[31:12];
      rd_q  <= instruction_word[11:7];
      pc_q  <= pc;
    end
  end

`ifdef RETIRE_CNT_EN
  // Counts every done pulse (rd==0 included), wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (done_d) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_u_type_exec_ctrl.sv
module tb_u_type_exec_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam int K_WB  = 0;
  localparam int K_RD0 = 1;
  localparam int K_ILL = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction_word;
  logic [XLEN-1:0]  pc;
  logic             wb_req;
  logic             wb_gnt;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic             done;
  logic             illegal;
`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  u_type_exec_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instruction_word (instruction_word),
    .pc               (pc),
    .wb_req           (wb_req),
    .wb_gnt           (wb_gnt),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .done             (done),
    .illegal          (illegal)
`ifdef RETIRE_CNT_EN
    ,
    .retire_cnt       (retire_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  function automatic bit is_u(input logic [31:0] instr);
    return (instr[6:0] == OPC_LUI) || (instr[6:0] == OPC_AUIPC);
  endfunction

  function automatic logic [31:0] u_result(input logic [31:0] instr, input logic [31:0] a_pc);
    logic [31:0] upper;
    upper = instr & 32'hFFFF_F000;
    return (instr[6:0] == OPC_AUIPC) ? upper + a_pc : upper;
  endfunction

  // Transaction timeline: an accepted instruction spends one edge in
  // execute, then (if it writes) waits for a sampled grant.
  bit               m_busy, m_waiting, m_ready, m_req, m_done, m_ill;
  logic [4:0]       m_rd;
  logic [31:0]      m_data;
  logic [CNT_W-1:0] m_cnt;
  logic [31:0]      p_instr, p_pc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_waiting = 0; m_ready = 1; m_req = 0;
      m_done = 0; m_ill = 0; m_rd = '0; m_data = '0; m_cnt = '0;
    end else begin
      m_done = 0;
      m_ill  = 0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_waiting = 0; m_ready = 0;
          p_instr = instruction_word; p_pc = pc;
        end
      end else if (!m_waiting) begin
        if (!is_u(p_instr)) begin
          m_ill = 1; m_busy = 0; m_ready = 1;
        end else if (p_instr[11:7] == 5'd0) begin
          m_done = 1; m_cnt = m_cnt + 1'b1; m_busy = 0; m_ready = 1;
        end else begin
          m_waiting = 1; m_req = 1;
          m_rd = p_instr[11:7];
          m_data = u_result(p_instr, p_pc);
        end
      end else if (wb_gnt) begin
        m_req = 0; m_done = 1; m_cnt = m_cnt + 1'b1;
        m_busy = 0; m_waiting = 0; m_ready = 1;
      end
    end
  end

  // Per-cycle compare against the reference.
  always @(negedge clk) begin
    if (check_en) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("wb_req", 32'(wb_req), 32'(m_req));
      check("done", 32'(done), 32'(m_done));
      check("illegal", 32'(illegal), 32'(m_ill));
      check("done_illegal_excl", 32'(done & illegal), 32'd0);
      if (m_req) begin
        check("wb_rd", 32'(wb_rd), 32'(m_rd));
        check("wb_data", wb_data, m_data);
      end
`ifdef RETIRE_CNT_EN
      check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
`endif
    end
  end

  // ---------------- directed transaction ----------------
  // Starts and ends at 1 time unit after a rising edge.
  task automatic run_txn(input logic [31:0] instr, input logic [31:0] a_pc, input int d,
                         input int kind, input logic [4:0] lit_rd, input logic [31:0] lit_data);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1; instruction_word = instr; pc = a_pc; wb_gnt = (d == 0);
    @(posedge clk); #1;                      // accept edge
    in_valid = 1'b0; instruction_word = $urandom; pc = $urandom;
    check("exec_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;                      // execute edge
    case (kind)
      K_ILL: begin
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_no_req", 32'(wb_req), 32'd0);
        check("ill_no_done", 32'(done), 32'd0);
      end
      K_RD0: begin
        check("rd0_done", 32'(done), 32'd1);
        check("rd0_no_req", 32'(wb_req), 32'd0);
      end
      default: begin
        check("lit_wb_req", 32'(wb_req), 32'd1);
        check("lit_wb_rd", 32'(wb_rd), 32'(lit_rd));
        check("lit_wb_data", wb_data, lit_data);
        check("lit_no_done", 32'(done), 32'd0);
        for (int k = 0; k < d; k++) begin
          @(posedge clk); #1;
          if (k == 0) begin
            in_valid = 1'b1; instruction_word = 32'h00ABC0B7; pc = 32'h40;
          end else begin
            in_valid = 1'b0;
          end
          check("hold_wb_req", 32'(wb_req), 32'd1);
          check("hold_wb_rd", 32'(wb_rd), 32'(lit_rd));
          check("hold_wb_data", wb_data, lit_data);
          check("hold_in_ready", 32'(in_ready), 32'd0);
          check("hold_no_done", 32'(done), 32'd0);
        end
        in_valid = 1'b0;
        wb_gnt = 1'b1;
        @(posedge clk); #1;                  // grant sampled
        wb_gnt = 1'b0;
        check("gnt_done", 32'(done), 32'd1);
        check("gnt_req_clr", 32'(wb_req), 32'd0);
      end
    endcase
    check("back_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("pulse_end_done", 32'(done), 32'd0);
    check("pulse_end_ill", 32'(illegal), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [CNT_W-1:0] cnt_snap;
    rst_n = 1'b1; in_valid = 1'b0; wb_gnt = 1'b0; instruction_word = '0; pc = '0;
    #1 rst_n = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_req", 32'(wb_req), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
`ifdef RETIRE_CNT_EN
    check("rst_retire_cnt", 32'(retire_cnt), 32'd0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;

    // rd==0 retirement first so the counter goes 0 -> 1.
    run_txn(32'h00001037, 32'h0, 0, K_RD0, 5'd0, 32'h0);
`ifdef RETIRE_CNT_EN
    check("rd0_retire_cnt", 32'(retire_cnt), 32'd1);
    cnt_snap = retire_cnt;
`else
    cnt_snap = '0;
`endif
    run_txn(32'h00000013, 32'h0, 0, K_ILL, 5'd0, 32'h0);
`ifdef RETIRE_CNT_EN
    check("ill_retire_cnt", 32'(retire_cnt), 32'(cnt_snap));
`endif
    run_txn(32'h123452B7, 32'h00000000, 0, K_WB, 5'd5, 32'h12345000);
    run_txn(32'h00001197, 32'h00000100, 0, K_WB, 5'd3, 32'h00001100);
    run_txn(32'hFFFFF197, 32'h00002000, 0, K_WB, 5'd3, 32'h00001000);
    run_txn(32'h0BEEF537, 32'h00000000, 3, K_WB, 5'd10, 32'h0BEEF000);

    // Reset while a write request is pending.
    in_valid = 1'b1; instruction_word = 32'hABCDE3B7; pc = 32'h0; wb_gnt = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", 32'(wb_req), 32'd1);
    check("pre_rst_rd", 32'(wb_rd), 32'd7);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(wb_req), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_done", 32'(done), 32'd0);
    run_txn(32'h123452B7, 32'h00000000, 0, K_WB, 5'd5, 32'h12345000);

    // Randomized traffic against the reference.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 2) != 0);
      wb_gnt   = ($urandom_range(0, 3) != 0);
      r = $urandom;
      case ($urandom_range(0, 3))
        0: r[6:0] = OPC_LUI;
        1: r[6:0] = OPC_AUIPC;
        2: begin r[6:0] = OPC_AUIPC; r[11:7] = 5'd0; end
        default: ;
      endcase
      instruction_word = r;
      pc = $urandom;
    end
    in_valid = 1'b0; wb_gnt = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_ready", 32'(in_ready), 32'd1);
    check("drain_req", 32'(wb_req), 32'd0);
    @(negedge clk);
    check_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
